// File: rtl/ddr_20g_adc_gen.sv
// Test-pattern source for the 20G ADC -> DDR path: emits incrementing 16-bit lane words
// with burst/gap control, ready back-pressure and single-word error injection.
module ddr_20g_adc_gen #(
  parameter int DATA_WD = 256,
  parameter int CNT_WD  = 32,
  parameter int GAP_WD  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_rst,
  input  logic               cfg_en,
  input  logic [CNT_WD-1:0]  cfg_word_num,
  input  logic [GAP_WD-1:0]  cfg_gap,
  input  logic               cfg_err_inj,
  input  logic               adc_rdy,
  output logic               adc_vld,
  output logic [DATA_WD-1:0] adc_data,
  output logic               busy,
  output logic               done,
  output logic [CNT_WD-1:0]  tx_cnt
);

  localparam int LANES = DATA_WD / 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        base_q, base_d;
  logic               pair_q, pair_d;
  logic [CNT_WD-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_WD-1:0]  tx_cnt_q, tx_cnt_d;
  logic [GAP_WD-1:0]  gap_cnt_q, gap_cnt_d;
  logic               inj_arm_q, inj_arm_d;
  logic               word_inj_q, word_inj_d;
  logic               rearm_q, rearm_d;
  logic               adc_vld_q, vld_d;
  logic [DATA_WD-1:0] adc_data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept_s;
  logic               load_s;

  // Lane k carries base + (k mod 4); flip inverts bit 0 of the whole word.
  function automatic logic [DATA_WD-1:0] pattern_word(input logic [15:0] base, input logic flip);
    logic [DATA_WD-1:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      w[16*k +: 16] = base + 16'(k % 4);
    end
    w[0] = w[0] ^ flip;
    return w;
  endfunction

  // Next-state, pattern advance and registered-output precompute.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    pair_d     = pair_q;
    word_cnt_d = word_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    inj_arm_d  = inj_arm_q | cfg_err_inj;
    word_inj_d = word_inj_q;
    rearm_d    = rearm_q & cfg_en;
    vld_d      = 1'b0;
    data_d     = adc_data_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    load_s     = 1'b0;
    accept_s   = adc_vld_q & adc_rdy;

    case (state_q)
      S_IDLE: begin
        if (cfg_en && !rearm_q) begin
          state_d    = S_SEND;
          word_cnt_d = '0;
          load_s     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (accept_s) begin
          word_cnt_d = word_cnt_q + CNT_WD'(1);
          tx_cnt_d   = tx_cnt_q + CNT_WD'(1);
          if (pair_q) begin
            base_d = base_q + 16'd4;
            pair_d = 1'b0;
          end else begin
            pair_d = 1'b1;
          end
          // An armed pulse arriving together with the injected word's acceptance is absorbed.
          if (word_inj_q) begin
            inj_arm_d = 1'b0;
          end else begin
            inj_arm_d = inj_arm_q | cfg_err_inj;
          end
          if ((cfg_word_num != '0) && ((word_cnt_q + CNT_WD'(1)) == cfg_word_num)) begin
            state_d = S_DONE;
            rearm_d = 1'b1;
          end else if (!cfg_en) begin
            state_d = S_IDLE;
          end else if (cfg_gap != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = cfg_gap;
          end else begin
            load_s = 1'b1;
          end
        end else begin
          vld_d = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_WD'(1)) begin
          if (cfg_en) begin
            state_d = S_SEND;
            load_s  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WD'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_s) begin
      vld_d      = 1'b1;
      data_d     = pattern_word(base_d, inj_arm_d);
      word_inj_d = inj_arm_d;
    end else begin
      word_inj_d = word_inj_q;
    end

    if (cfg_rst) begin
      state_d    = S_IDLE;
      base_d     = 16'd0;
      pair_d     = 1'b0;
      word_cnt_d = '0;
      tx_cnt_d   = '0;
      gap_cnt_d  = '0;
      inj_arm_d  = 1'b0;
      word_inj_d = 1'b0;
      rearm_d    = 1'b0;
      vld_d      = 1'b0;
      data_d     = '0;
    end else begin
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= 16'd0;
      pair_q     <= 1'b0;
      word_cnt_q <= '0;
      tx_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      inj_arm_q  <= 1'b0;
      word_inj_q <= 1'b0;
      rearm_q    <= 1'b0;
      adc_vld_q  <= 1'b0;
      adc_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      pair_q     <= pair_d;
      word_cnt_q <= word_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      inj_arm_q  <= inj_arm_d;
      word_inj_q <= word_inj_d;
      rearm_q    <= rearm_d;
      adc_vld_q  <= vld_d;
      adc_data_q <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign adc_vld  = adc_vld_q;
  assign adc_data = adc_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_cnt   = tx_cnt_q;

endmodule

// File: tb/tb_ddr_20g_adc_gen.sv
// Directed + randomized bench for ddr_20g_adc_gen against a word-index pattern model.
module tb_ddr_20g_adc_gen;

  localparam int DATA_WD = 256;
  localparam int CNT_WD  = 32;
  localparam int GAP_WD  = 16;

  logic               clk = 1'b0;
  logic               rst_n, cfg_rst, cfg_en, cfg_err_inj, adc_rdy;
  logic [CNT_WD-1:0]  cfg_word_num;
  logic [GAP_WD-1:0]  cfg_gap;
  logic               adc_vld, busy, done;
  logic [DATA_WD-1:0] adc_data;
  logic [CNT_WD-1:0]  tx_cnt;

  ddr_20g_adc_gen #(.DATA_WD(DATA_WD), .CNT_WD(CNT_WD), .GAP_WD(GAP_WD)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst), .cfg_en(cfg_en),
    .cfg_word_num(cfg_word_num), .cfg_gap(cfg_gap), .cfg_err_inj(cfg_err_inj),
    .adc_rdy(adc_rdy), .adc_vld(adc_vld), .adc_data(adc_data), .busy(busy),
    .done(done), .tx_cnt(tx_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_acc = 0;
  logic [CNT_WD-1:0] exp_tx = '0;
  bit arm = 1'b0, cur_flip = 1'b0, prev_vld = 1'b0, prev_acc = 1'b0;
  int suc = 0, err = 0, done_cnt = 0;
  logic [DATA_WD-1:0] held = '0;

  // Word n (0-based since reset) carries base (n/2)*4 mod 2^16 in every group of 4 lanes.
  function automatic logic [DATA_WD-1:0] exp_word(input int n, input bit flip);
    logic [DATA_WD-1:0] w;
    logic [15:0] b;
    b = 16'((n / 2) * 4);
    for (int k = 0; k < DATA_WD / 16; k++) w[16*k +: 16] = b + 16'(k % 4);
    w[0] = w[0] ^ flip;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [DATA_WD-1:0] obs, input logic [DATA_WD-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check the presented word, update the model, advance, check tx_cnt.
  task automatic tick();
    bit acc, rst_now;
    acc     = adc_vld && adc_rdy;
    rst_now = cfg_rst;
    if (adc_vld) chk("data", adc_data, exp_word(n_acc, cur_flip));
    if (prev_vld && !prev_acc) begin
      chk("hold_vld", {255'd0, adc_vld}, 256'd1);
      chk("hold_data", adc_data, held);
    end
    if (acc) begin
      if (adc_data === exp_word(n_acc, 1'b0)) suc++;
      else err++;
    end
    arm = arm | cfg_err_inj;
    if (acc && cur_flip) arm = 1'b0;
    if (acc) begin
      n_acc++;
      exp_tx = exp_tx + 32'd1;
    end
    held = adc_data; prev_vld = adc_vld; prev_acc = acc;
    @(posedge clk); #1;
    cfg_err_inj = 1'b0;
    if (rst_now) begin
      n_acc = 0; exp_tx = '0; arm = 1'b0; cur_flip = 1'b0; prev_vld = 1'b0;
      chk("rst_vld", {255'd0, adc_vld}, 256'd0);
    end else if (adc_vld && (!prev_vld || prev_acc)) begin
      cur_flip = arm;
    end
    if (done) done_cnt++;
    chk("tx_cnt", tx_cnt, exp_tx);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy && !adc_vld) break;
      tick();
    end
    tick();
    chk("idle_busy", {255'd0, busy}, 256'd0);
  endtask

  logic [11:0] vh, dh, bh;
  logic [63:0] w3;
  int suc0, err0, done0;

  initial begin
    rst_n = 1'b0; cfg_rst = 1'b0; cfg_en = 1'b0; cfg_err_inj = 1'b0; adc_rdy = 1'b0;
    cfg_word_num = '0; cfg_gap = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_adc_vld", {255'd0, adc_vld}, 256'd0);
    chk("rst_adc_data", adc_data, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_done", {255'd0, done}, 256'd0);
    chk("rst_tx_cnt", tx_cnt, 256'd0);
    rst_n = 1'b1;
    tick();

    // 4-word burst, no gap, always ready
    cfg_word_num = 32'd4; cfg_gap = 16'd0; adc_rdy = 1'b1; cfg_en = 1'b1;
    vh = '0; dh = '0; bh = '0; w3 = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      vh[i] = adc_vld; dh[i] = done; bh[i] = busy;
      if (i == 2) w3 = adc_data[63:0];
    end
    chk("burst_vld_seq", {248'd0, vh[7:0]}, 256'h0f);
    chk("burst_done_seq", {248'd0, dh[7:0]}, 256'h10);
    chk("burst_busy_seq", {248'd0, bh[7:0]}, 256'h1f);
    chk("burst_word3_lanes", {192'd0, w3}, {192'd0, 64'h0007_0006_0005_0004});
    chk("burst_tx_cnt", tx_cnt, 256'd4);
    cfg_en = 1'b0;
    wait_idle();

    // back-pressure on word 2
    suc0 = suc; err0 = err; done0 = done_cnt;
    cfg_en = 1'b1;
    tick(); tick();
    adc_rdy = 1'b0;
    repeat (5) tick();
    adc_rdy = 1'b1;
    repeat (10) tick();
    chk("bp_suc", 256'(suc - suc0), 256'd4);
    chk("bp_err", 256'(err - err0), 256'd0);
    chk("bp_done", 256'(done_cnt - done0), 256'd1);
    cfg_en = 1'b0;
    wait_idle();

    // continuous with gap 3
    cfg_word_num = 32'd0; cfg_gap = 16'd3; cfg_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      vh[i] = adc_vld;
    end
    chk("gap_vld_seq", {244'd0, vh}, {244'd0, 12'b0001_0001_0001});
    cfg_en = 1'b0;
    wait_idle();

    // error injection on word 3 of a 6-word burst from a fresh pattern
    cfg_rst = 1'b1; tick(); cfg_rst = 1'b0;
    suc0 = suc; err0 = err;
    cfg_word_num = 32'd6; cfg_gap = 16'd0; cfg_en = 1'b1;
    tick(); tick();
    cfg_err_inj = 1'b1;
    tick();
    chk("inj_word3_lane0", {240'd0, adc_data[15:0]}, 256'h5);
    repeat (8) tick();
    chk("inj_suc", 256'(suc - suc0), 256'd5);
    chk("inj_err", 256'(err - err0), 256'd1);
    cfg_en = 1'b0;
    wait_idle();

    // cfg_rst mid-handshake
    cfg_word_num = 32'd0; cfg_en = 1'b1; adc_rdy = 1'b0;
    tick(); tick();
    cfg_rst = 1'b1; tick(); cfg_rst = 1'b0;
    chk("srst_tx_cnt", tx_cnt, 256'd0);
    tick();
    chk("srst_restart_lanes", {192'd0, adc_data[63:0]}, {192'd0, 64'h0003_0002_0001_0000});
    adc_rdy = 1'b1; cfg_en = 1'b0;
    wait_idle();

    // randomized traffic against the model
    cfg_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      adc_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) cfg_en = ~cfg_en;
      cfg_gap      = 16'($urandom_range(0, 3));
      cfg_word_num = 32'($urandom_range(0, 5));
      cfg_err_inj  = ($urandom_range(0, 19) == 0);
      cfg_rst      = ($urandom_range(0, 149) == 0);
      tick();
      cfg_rst = 1'b0;
    end
    cfg_en = 1'b0; adc_rdy = 1'b1;
    wait_idle();

    // long continuous run across the 16-bit base wrap
    cfg_rst = 1'b1; tick(); cfg_rst = 1'b0;
    cfg_word_num = 32'd0; cfg_gap = 16'd0; adc_rdy = 1'b1; cfg_en = 1'b1;
    for (int i = 0; i < 33000; i++) begin
      if (exp_tx == 32'd32770) break;
      if (adc_vld && n_acc == 32766) chk("wrap_lane3", {240'd0, adc_data[63:48]}, 256'hffff);
      if (adc_vld && n_acc == 32768) chk("wrap_lane0", {240'd0, adc_data[15:0]}, 256'h0);
      tick();
    end
    chk("long_tx_cnt", tx_cnt, 256'd32770);
    cfg_en = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
